// File: rtl/dct_transpose_buffer.sv
// Ping-pong 8x8 transpose buffer between the row and column 1D-DCT stages.
// Blocks are written row-major into one bank while the other bank replays column-major.
module dct_transpose_buffer #(
   parameter int DATA_W     = 16,
   parameter int NUM_BLOCKS = 256
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic              out_last_o,
   output logic              frame_done_o
);

   localparam int               BLK_W    = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(NUM_BLOCKS - 1);

   logic [DATA_W-1:0] mem_q [2][64];

   logic [1:0]       full_q,  full_d;
   logic             wbank_q, wbank_d;
   logic             rbank_q, rbank_d;
   logic [5:0]       wcnt_q,  wcnt_d;
   logic [5:0]       rcnt_q,  rcnt_d;
   logic [BLK_W-1:0] blk_q,   blk_d;
   logic             fdone_q, fdone_d;

   logic       wr_en;
   logic       rd_en;
   logic [5:0] raddr;

   assign in_ready_o   = ~full_q[wbank_q];
   assign wr_en        = in_valid_i & in_ready_o;
   assign out_valid_o  = full_q[rbank_q];
   assign rd_en        = out_valid_o & out_ready_i;
   // Swapping the counter halves turns a row-major address into column-major order.
   assign raddr        = {rcnt_q[2:0], rcnt_q[5:3]};
   assign out_data_o   = mem_q[rbank_q][raddr];
   assign out_last_o   = out_valid_o & (rcnt_q == 6'd63);
   assign frame_done_o = fdone_q;

   always_comb begin
      full_d  = full_q;
      wbank_d = wbank_q;
      rbank_d = rbank_q;
      wcnt_d  = wcnt_q;
      rcnt_d  = rcnt_q;
      blk_d   = blk_q;
      fdone_d = 1'b0;
      if (wr_en) begin
         wcnt_d = wcnt_q + 6'd1;
         if (wcnt_q == 6'd63) begin
            full_d[wbank_q] = 1'b1;
            wbank_d         = ~wbank_q;
         end
      end
      // Set and clear always target different banks, so both updates can land together.
      if (rd_en) begin
         rcnt_d = rcnt_q + 6'd1;
         if (rcnt_q == 6'd63) begin
            full_d[rbank_q] = 1'b0;
            rbank_d         = ~rbank_q;
            if (blk_q == BLK_LAST) begin
               blk_d   = '0;
               fdone_d = 1'b1;
            end else begin
               blk_d = blk_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         full_q  <= '0;
         wbank_q <= 1'b0;
         rbank_q <= 1'b0;
         wcnt_q  <= '0;
         rcnt_q  <= '0;
         blk_q   <= '0;
         fdone_q <= 1'b0;
      end else begin
         full_q  <= full_d;
         wbank_q <= wbank_d;
         rbank_q <= rbank_d;
         wcnt_q  <= wcnt_d;
         rcnt_q  <= rcnt_d;
         blk_q   <= blk_d;
         fdone_q <= fdone_d;
      end
   end

   // Bank contents are deliberately not reset.
   always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[wbank_q][wcnt_q] <= in_data_i;
   end

endmodule
